exe_stage_mc: RTL
=================

Name: exe_stage_mc

Overview:
- Parametrised, pipelined successor to the combinational execute stage of the in-order pipeline.
- Computes the ALU result, branch target and branch decision, and adds iterative multi-cycle multiply/divide.
- Adds valid/ready handshakes on both sides so ID/EXE can stall upstream and EXE/MEM can stall downstream.
- All outputs are registered; sits between the ID/EXE and EXE/MEM pipeline registers.

Parameters:
- WIDTH, 32, datapath width of val1, val2, src2_val, pc, result and branch address (power of two, >=8).
- BR_SHIFT, 2, left shift applied to val2 before it is added to pc.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight operation and of the output register.
- in_valid  in  1  operands and command are valid.
- in_ready  out  1  stage accepts an operation this cycle.
- exe_cmd  in  4  operation select; encoding under Behaviour.
- branch_type  in  2  00 none, 01 BEZ (val1==0), 10 BNE (val1!=src2_val), 11 JMP (always taken).
- val1  in  WIDTH  operand A.
- val2  in  WIDTH  operand B; also the branch offset.
- src2_val  in  WIDTH  compare value for BNE.
- pc  in  WIDTH  pc of the operation.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result this cycle.
- alu_result  out  WIDTH  registered result.
- branch_address  out  WIDTH  registered pc + (val2<<BR_SHIFT), mod 2^WIDTH.
- branch_taken  out  1  registered branch decision.

Behaviour:
- Reset: state IDLE; out_valid, branch_taken, alu_result and branch_address all 0; in_ready 0 while rst is high.
- Accept: an operation is accepted when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Command encoding (shifts act on val1, amount = val2[log2(WIDTH)-1:0]):
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL.
  - 1100 MUL: low WIDTH bits of the unsigned product, multi-cycle.
  - 1101 DIVU: quotient, multi-cycle.
  - 1110 REMU: remainder, multi-cycle.
  - Any other code: result 0, single-cycle.
- Arithmetic wraps modulo 2^WIDTH; no flags.
- Branch decision and branch address are computed from the inputs at accept and held in registers. They are presented together with the result, for every command type.
- Single-cycle ops:
  - Outputs load at the accepting edge, so out_valid is 1 on the next cycle (latency 1).
  - Back-to-back issue at one operation per cycle is sustained while out_ready is 1.
- Multi-cycle ops:
  - States: IDLE -> ITER at accept; counter loads WIDTH.
  - MUL: shift-add, one bit per cycle. DIVU/REMU: restoring division, one bit per cycle.
  - ITER -> IDLE when the counter reaches 0; the output register loads on the same edge.
  - out_valid rises WIDTH+1 cycles after the accepting edge.
  - in_ready is 0 throughout ITER.
- Divide by zero: quotient all ones, remainder = val1; takes the same latency as a normal divide.
- Output hold:
  - While out_valid && !out_ready, all outputs stay stable and in_ready is 0.
  - An operation finishing ITER while the output is still occupied waits in ITER with counter 0 until the output frees. The output then loads on the edge where out_ready is seen.
- Flush:
  - Forces state IDLE and out_valid 0 at the next edge.
  - Flush has priority over a simultaneous accept; that operation is discarded.
  - Flush has priority over ITER completion.
- rst mid-ITER aborts immediately to reset values; no partial result is ever presented.
- branch_taken and alu_result are meaningful only while out_valid is 1, but they remain deterministic.

Test Plan:
- ADD val1=0xFFFFFFFF, val2=1, in_valid held 1 cycle, out_ready=1 -> next cycle out_valid=1, alu_result=0, branch_address=pc+4.
- BNE val1=5, src2_val=5, then BNE val1=5, src2_val=6, back-to-back -> branch_taken 0 then 1 on consecutive cycles; in_ready stays 1.
- MUL 0x10000 * 0x10000 then MUL 7*6 -> results 0 and 42; each appears 33 cycles after accept; in_ready=0 during ITER.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- out_ready=0 for 5 cycles after a SUB 3-5 result -> alu_result=0xFFFFFFFE held stable, in_ready=0; after out_ready=1 the next operation is accepted.
- Flush at cycle 10 of a DIVU, and rst asserted mid-MUL -> out_valid never rises for those operations; the next ADD after release completes in 1 cycle.

Source files
------------

// File: rtl/exe_if.sv
// Handshake and operand/result bundle between the ID/EXE register, the
// execute stage and the EXE/MEM register.
interface exe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exe_cmd;
    logic [1:0]       branch_type;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] src2_val;
    logic [WIDTH-1:0] pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] branch_address;
    logic             branch_taken;

    modport slave (
        input  in_valid, exe_cmd, branch_type, val1, val2, src2_val, pc, out_ready,
        output in_ready, out_valid, alu_result, branch_address, branch_taken
    );

    modport master (
        output in_valid, exe_cmd, branch_type, val1, val2, src2_val, pc, out_ready,
        input  in_ready, out_valid, alu_result, branch_address, branch_taken
    );
endinterface

// File: rtl/exe_stage_mc.sv
// Pipelined execute stage: single-cycle ALU/branch plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module exe_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    exe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic {IDLE, ITER} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIVU, OP_REMU} mop_t;

    state_t           state;
    mop_t             mop;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic             pend_taken;
    logic [WIDTH-1:0] pend_addr;
    logic             out_valid_q, taken_q;
    logic [WIDTH-1:0] result_q, addr_q;

    logic             out_free, accept, is_multi, br_taken;
    logic [WIDTH-1:0] alu_val, br_addr, multi_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;

    assign out_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !rst && (state == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid      = out_valid_q;
    assign bus.alu_result     = result_q;
    assign bus.branch_address = addr_q;
    assign bus.branch_taken   = taken_q;

    assign shamt    = bus.val2[SHW-1:0];
    assign br_addr  = bus.pc + (bus.val2 << BR_SHIFT);
    assign is_multi = (bus.exe_cmd[3:2] == 2'b11) && (bus.exe_cmd[1:0] != 2'b11);

    always_comb begin
        alu_val = '0;
        case (bus.exe_cmd)
            4'b0000: alu_val = bus.val1 + bus.val2;
            4'b0010: alu_val = bus.val1 - bus.val2;
            4'b0100: alu_val = bus.val1 & bus.val2;
            4'b0101: alu_val = bus.val1 | bus.val2;
            4'b0110: alu_val = ~(bus.val1 | bus.val2);
            4'b0111: alu_val = bus.val1 ^ bus.val2;
            4'b1000: alu_val = bus.val1 << shamt;
            4'b1001: alu_val = $unsigned($signed(bus.val1) >>> shamt);
            4'b1010: alu_val = bus.val1 >> shamt;
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (bus.branch_type)
            2'b01:   br_taken = (bus.val1 == '0);
            2'b10:   br_taken = (bus.val1 != bus.src2_val);
            2'b11:   br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Division keeps the partial remainder in acc and shifts the dividend
    // out of op_b while quotient bits shift in; divisor sits in op_a.
    assign div_sh = {acc, op_b[WIDTH-1]};
    assign div_ge = (div_sh >= {1'b0, op_a});

    always_comb begin
        multi_res = '0;
        case (mop)
            OP_MUL:  multi_res = acc;
            OP_DIVU: multi_res = op_b;
            OP_REMU: multi_res = acc;
            default: multi_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mop         <= OP_MUL;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            pend_taken  <= 1'b0;
            pend_addr   <= '0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            result_q    <= '0;
            addr_q      <= '0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state      <= ITER;
                            cnt        <= CW'(WIDTH);
                            acc        <= '0;
                            pend_taken <= br_taken;
                            pend_addr  <= br_addr;
                            if (bus.exe_cmd == 4'b1100) begin
                                mop  <= OP_MUL;
                                op_a <= bus.val1;
                                op_b <= bus.val2;
                            end else begin
                                mop  <= (bus.exe_cmd[1:0] == 2'b01) ? OP_DIVU : OP_REMU;
                                op_a <= bus.val2;
                                op_b <= bus.val1;
                            end
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_val;
                            addr_q      <= br_addr;
                            taken_q     <= br_taken;
                        end
                    end
                end
                ITER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (mop == OP_MUL) begin
                            if (op_b[0])
                                acc <= acc + op_a;
                            op_a <= op_a << 1;
                            op_b <= op_b >> 1;
                        end else begin
                            acc  <= div_ge ? (div_sh[WIDTH-1:0] - op_a) : div_sh[WIDTH-1:0];
                            op_b <= {op_b[WIDTH-2:0], div_ge};
                        end
                    end else if (out_free) begin
                        // finished result waits here until the output register frees
                        state       <= IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= multi_res;
                        addr_q      <= pend_addr;
                        taken_q     <= pend_taken;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
